// File: rtl/cpu_timing_gen.sv
// cpu_timing_gen: 7 MHz enable, raster counters, frame interrupt, ULA contention
// and 3.5 MHz-aligned speed retiming, all derived from clk_28.
module cpu_timing_gen #(
    parameter int H_TOTAL    = 448,
    parameter int V_TOTAL    = 312,
    parameter int V_ACTIVE   = 192,
    parameter int CONT_START = 0,
    parameter int INT_LINE   = 248,
    parameter int INT_LEN    = 64
) (
    input  logic       clk_28,
    input  logic       reset_n,
    input  logic [1:0] cpu_speed_req,
    input  logic       contention_en,
    input  logic       cpu_req_contended,
    output logic       ce_7,
    output logic [8:0] hc,
    output logic [8:0] vc,
    output logic [1:0] cpu_speed,
    output logic       cpu_clk_lsb,
    output logic       cpu_contend,
    output logic       int_n
);
    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] VA     = 9'(V_ACTIVE);
    localparam logic [8:0] CS     = 9'(CONT_START);
    localparam logic [8:0] INT_VC = 9'(INT_LINE);
    localparam logic [8:0] INT_HC = 9'(INT_LEN);
    localparam logic       INT_EN = INT_LINE < V_TOTAL;

    // An interrupt pulse must never straddle the end of a line.
    if (INT_LEN >= H_TOTAL) begin : g_int_len_check
        $error("cpu_timing_gen: INT_LEN must be less than H_TOTAL");
    end

    logic [1:0] phase_q, phase_d;
    logic       ce_7_q, ce_7_d;
    logic [8:0] hc_q, hc_d, vc_q, vc_d;
    logic [1:0] speed_q, speed_d;
    logic       lsb_q, lsb_d;
    logic       contend_q, contend_d;
    logic       int_n_q, int_n_d;
    logic       tick;
    logic [8:0] hc_nx, vc_nx, off;
    logic [1:0] speed_nx;
    logic       contend_nx, int_n_nx;

    always_comb begin
        tick       = phase_q == 2'd3;
        phase_d    = phase_q + 2'd1;
        ce_7_d     = tick;
        hc_nx      = (hc_q == H_LAST) ? 9'd0 : hc_q + 9'd1;
        vc_nx      = (hc_q != H_LAST) ? vc_q : (vc_q == V_LAST) ? 9'd0 : vc_q + 9'd1;
        speed_nx   = hc_nx[0] ? speed_q : cpu_speed_req;
        off        = hc_nx - CS;
        // 6 stretched / 2 free T-states per 8, only while the new speed is 3.5 MHz
        contend_nx = contention_en && cpu_req_contended && (speed_nx == 2'd0) &&
                     (vc_nx < VA) && (off < 9'd256) && (off[3:1] <= 3'd5);
        int_n_nx   = !(INT_EN && (vc_nx == INT_VC) && (hc_nx < INT_HC));
        hc_d       = tick ? hc_nx : hc_q;
        vc_d       = tick ? vc_nx : vc_q;
        speed_d    = tick ? speed_nx : speed_q;
        lsb_d      = tick ? hc_nx[0] : lsb_q;
        contend_d  = tick ? contend_nx : contend_q;
        int_n_d    = tick ? int_n_nx : int_n_q;
    end

    always_ff @(posedge clk_28 or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= 2'd0;
            ce_7_q    <= 1'b0;
            hc_q      <= 9'd0;
            vc_q      <= 9'd0;
            speed_q   <= 2'd0;
            lsb_q     <= 1'b0;
            contend_q <= 1'b0;
            int_n_q   <= 1'b1;
        end else begin
            phase_q   <= phase_d;
            ce_7_q    <= ce_7_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            speed_q   <= speed_d;
            lsb_q     <= lsb_d;
            contend_q <= contend_d;
            int_n_q   <= int_n_d;
        end
    end

    assign ce_7        = ce_7_q;
    assign hc          = hc_q;
    assign vc          = vc_q;
    assign cpu_speed   = speed_q;
    assign cpu_clk_lsb = lsb_q;
    assign cpu_contend = contend_q;
    assign int_n       = int_n_q;
endmodule

// File: tb/tb_cpu_timing_gen.sv
// tb_cpu_timing_gen: three instances (default, CONT_START=14, tiny frame) checked
// every clk_28 cycle against an arithmetic model of the raster timing.
module tb_cpu_timing_gen;
    localparam int HT[3] = '{448, 448, 32};
    localparam int VT[3] = '{312, 312, 10};
    localparam int VA[3] = '{192, 192, 4};
    localparam int CS[3] = '{0, 14, 20};
    localparam int IL[3] = '{248, 248, 7};
    localparam int IS[3] = '{64, 64, 6};

    logic       clk_28 = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] cpu_speed_req = 2'd0;
    logic       contention_en = 1'b0;
    logic       cpu_req_contended = 1'b0;
    logic       ce_o[3];
    logic [8:0] hc_o[3];
    logic [8:0] vc_o[3];
    logic [1:0] spd_o[3];
    logic       lsb_o[3];
    logic       cont_o[3];
    logic       int_o[3];
    logic [23:0] got[3];

    int vectors = 0;
    int miscompares = 0;
    int n = 0;
    logic [1:0] spd_m[3] = '{2'd0, 2'd0, 2'd0};
    logic       cont_m[3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk_28 = ~clk_28;

    cpu_timing_gen dut0 (
        .clk_28(clk_28), .reset_n(reset_n), .cpu_speed_req(cpu_speed_req),
        .contention_en(contention_en), .cpu_req_contended(cpu_req_contended),
        .ce_7(ce_o[0]), .hc(hc_o[0]), .vc(vc_o[0]), .cpu_speed(spd_o[0]),
        .cpu_clk_lsb(lsb_o[0]), .cpu_contend(cont_o[0]), .int_n(int_o[0]));

    cpu_timing_gen #(.CONT_START(14)) dut1 (
        .clk_28(clk_28), .reset_n(reset_n), .cpu_speed_req(cpu_speed_req),
        .contention_en(contention_en), .cpu_req_contended(cpu_req_contended),
        .ce_7(ce_o[1]), .hc(hc_o[1]), .vc(vc_o[1]), .cpu_speed(spd_o[1]),
        .cpu_clk_lsb(lsb_o[1]), .cpu_contend(cont_o[1]), .int_n(int_o[1]));

    cpu_timing_gen #(.H_TOTAL(32), .V_TOTAL(10), .V_ACTIVE(4), .CONT_START(20),
                     .INT_LINE(7), .INT_LEN(6)) dut2 (
        .clk_28(clk_28), .reset_n(reset_n), .cpu_speed_req(cpu_speed_req),
        .contention_en(contention_en), .cpu_req_contended(cpu_req_contended),
        .ce_7(ce_o[2]), .hc(hc_o[2]), .vc(vc_o[2]), .cpu_speed(spd_o[2]),
        .cpu_clk_lsb(lsb_o[2]), .cpu_contend(cont_o[2]), .int_n(int_o[2]));

    always_comb
        for (int k = 0; k < 3; k++)
            got[k] = {ce_o[k], hc_o[k], vc_o[k], spd_o[k], lsb_o[k], cont_o[k], int_o[k]};

    function automatic int m_hc(int k);
        return (n / 4) % HT[k];
    endfunction

    function automatic int m_vc(int k);
        return ((n / 4) / HT[k]) % VT[k];
    endfunction

    function automatic logic [23:0] exp_vec(int k);
        int h = m_hc(k);
        int v = m_vc(k);
        return {1'(n > 0 && n % 4 == 0), 9'(h), 9'(v), spd_m[k], 1'(h % 2),
                cont_m[k], 1'(!(v == IL[k] && h < IS[k]))};
    endfunction

    // One clk_28 edge of the model; inputs are stable across the edge.
    task automatic advance();
        @(posedge clk_28);
        n++;
        if (n % 4 == 0)
            for (int k = 0; k < 3; k++) begin
                int h = m_hc(k);
                int v = m_vc(k);
                int off = ((h - CS[k]) % 512 + 512) % 512;
                if (h % 2 == 0) spd_m[k] = cpu_speed_req;
                cont_m[k] = contention_en && cpu_req_contended && spd_m[k] == 2'd0 &&
                            v < VA[k] && off < 256 && off % 16 < 12;
            end
        #1;
    endtask

    task automatic model_reset();
        n = 0;
        spd_m = '{2'd0, 2'd0, 2'd0};
        cont_m = '{1'b0, 1'b0, 1'b0};
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got[k] !== 24'h000001) begin
                miscompares++;
                $display("FAIL reset_state dut%0d got %h exp %h", k, got[k], 24'h000001);
            end
        end
        @(negedge clk_28);
        reset_n = 1'b1;
        repeat (16) begin
            advance();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (got[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL reset_run dut%0d n=%0d got %h exp %h", k, n, got[k], exp_vec(k));
                end
            end
        end
        vectors++;
        if (hc_o[0] !== 9'd4) begin
            miscompares++;
            $display("FAIL hc_after_16 got %0d exp 4", hc_o[0]);
        end
    endtask

    task automatic test_frame();
        int lows = 0;
        contention_en = 1'($urandom);
        cpu_req_contended = 1'($urandom);
        for (int c = 0; c < 3 * 1280; c++) begin
            advance();
            if (c >= 2 * 1280 && !int_o[2]) lows++;
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (got[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL frame_run dut%0d n=%0d got %h exp %h", k, n, got[k], exp_vec(k));
                end
            end
        end
        vectors++;
        if (lows !== 6 * 4) begin
            miscompares++;
            $display("FAIL int_len got %0d clk_28 cycles low exp %0d", lows, 6 * 4);
        end
    endtask

    task automatic test_contention();
        @(negedge clk_28);
        reset_n = 1'b0;
        model_reset();
        cpu_speed_req = 2'd0;
        contention_en = 1'b1;
        cpu_req_contended = 1'b1;
        @(negedge clk_28);
        reset_n = 1'b1;
        for (int c = 0; c < 11 * 448 * 4 + 200; c++) begin
            advance();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (got[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL cont_run dut%0d n=%0d got %h exp %h", k, n, got[k], exp_vec(k));
                end
            end
            if (n % 4 == 0 && m_vc(0) == 10 && m_hc(0) % 32 == 0) begin
                vectors++;
                if (cont_o[0] !== 1'(m_hc(0) < 256)) begin
                    miscompares++;
                    $display("FAIL cont_line10 hc=%0d got %b exp %b", m_hc(0), cont_o[0], m_hc(0) < 256);
                end
            end
        end
    endtask

    task automatic test_cont_start();
        for (int c = 0; c < 448 * 4; c++) begin
            advance();
            vectors++;
            if (got[1] !== exp_vec(1)) begin
                miscompares++;
                $display("FAIL cs_run n=%0d got %h exp %h", n, got[1], exp_vec(1));
            end
            if (n % 4 == 0 && (m_hc(1) == 13 || m_hc(1) == 14 || m_hc(1) == 265 || m_hc(1) == 270)) begin
                vectors++;
                if (cont_o[1] !== 1'(m_hc(1) == 14 || m_hc(1) == 265)) begin
                    miscompares++;
                    $display("FAIL cs_edge hc=%0d got %b", m_hc(1), cont_o[1]);
                end
            end
        end
    endtask

    task automatic test_speed();
        int tries = 0;
        while (!(n % 4 == 0 && m_hc(0) % 2 == 1) && tries < 16) begin
            advance();
            tries++;
        end
        vectors++;
        if (tries >= 16) begin
            miscompares++;
            $display("FAIL speed_wait no odd-hc tick within 16 cycles");
        end
        cpu_speed_req = 2'd3;
        repeat (3) advance();
        vectors++;
        if (spd_o[0] !== 2'd0) begin
            miscompares++;
            $display("FAIL speed_early got %0d exp 0", spd_o[0]);
        end
        advance();
        vectors++;
        if (spd_o[0] !== 2'd3 || cont_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL speed_switch got spd=%0d cont=%b exp spd=3 cont=0", spd_o[0], cont_o[0]);
        end
        cpu_speed_req = 2'd1;
        repeat (4) advance();
        cpu_speed_req = 2'd3;
        for (int c = 0; c < 400; c++) begin
            advance();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (got[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL speed_run dut%0d n=%0d got %h exp %h", k, n, got[k], exp_vec(k));
                end
            end
        end
        vectors++;
        if (spd_o[0] !== 2'd3 || cont_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL speed_hold got spd=%0d cont=%b exp spd=3 cont=0", spd_o[0], cont_o[0]);
        end
    endtask

    task automatic test_reset_mid();
        int tries = 0;
        cpu_speed_req = 2'd0;
        while (int_o[2] !== 1'b0 && tries < 1400) begin
            advance();
            tries++;
        end
        vectors++;
        if (tries >= 1400) begin
            miscompares++;
            $display("FAIL int_wait int_n never went low");
        end
        #2;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got[k] !== 24'h000001) begin
                miscompares++;
                $display("FAIL async_reset dut%0d got %h exp %h", k, got[k], 24'h000001);
            end
        end
        model_reset();
        @(negedge clk_28);
        @(negedge clk_28);
        reset_n = 1'b1;
        repeat (16) begin
            advance();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (got[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL restart dut%0d n=%0d got %h exp %h", k, n, got[k], exp_vec(k));
                end
            end
        end
        vectors++;
        if (hc_o[0] !== 9'd4) begin
            miscompares++;
            $display("FAIL restart_hc got %0d exp 4", hc_o[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(15) == 0) cpu_speed_req = 2'($urandom);
            contention_en = $urandom_range(7) != 0;
            cpu_req_contended = 1'($urandom);
            advance();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (got[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL random dut%0d n=%0d got %h exp %h", k, n, got[k], exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_contention();
        test_cont_start();
        test_speed();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
